// File: rtl/cosim_endpoint_rx_fifo_pkg.sv
// Shared constants and elaboration helpers for the cosim endpoint receive FIFO.
package cosim_rx_pkg;

    localparam int MIN_DEPTH = 2;

    // Bits needed to hold the values 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < (depth + 32'sd1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth > 0) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/cosim_endpoint_rx_fifo_if.sv
// Endpoint push side and consumer valid/ready side of the receive FIFO.
interface cosim_endpoint_rx_fifo_if
    import cosim_rx_pkg::*;
#(
    parameter int TYPE_SIZE_BITS = 32,
    parameter int DEPTH          = 4
);
    localparam int CNT_W = clog2_cnt(DEPTH);

    logic                      up_valid;
    logic                      up_ready;
    logic [TYPE_SIZE_BITS-1:0] up_data;
    logic                      dn_valid;
    logic                      dn_ready;
    logic [TYPE_SIZE_BITS-1:0] dn_data;
    logic [CNT_W-1:0]          occupancy;
    logic                      overflow;
    logic                      clr_overflow;

    modport master (
        output up_valid, up_data, dn_ready, clr_overflow,
        input  up_ready, dn_valid, dn_data, occupancy, overflow
    );

    modport slave (
        input  up_valid, up_data, dn_ready, clr_overflow,
        output up_ready, dn_valid, dn_data, occupancy, overflow
    );

endinterface

// File: rtl/cosim_endpoint_rx_fifo_chk.sv
// Simulation-only invariants on the FIFO occupancy and pop qualification.
module cosim_rx_fifo_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rstn,
    input logic [CNT_W-1:0] i_count,
    input logic             i_pop
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        i_count <= CNT_W'(DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
        !(i_pop && (i_count == {CNT_W{1'b0}})));

endmodule

// File: rtl/cosim_endpoint_rx_fifo_mem.sv
// Unreset register array: one synchronous write port, one asynchronous read port.
module cosim_rx_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Payload write at the write pointer.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cosim_endpoint_rx_fifo.sv
// Elastic receive FIFO absorbing a one-cycle-late endpoint push stream and
// presenting a hold-until-accepted valid/ready stream to user logic.
module cosim_endpoint_rx_fifo
    import cosim_rx_pkg::*;
#(
    parameter int TYPE_SIZE_BITS = 32,
    parameter int DEPTH          = 4
) (
    input logic                      clk,
    input logic                      rstn,
    cosim_endpoint_rx_fifo_if.slave  bus
);

    localparam int CNT_W = clog2_cnt(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    if ((DEPTH < MIN_DEPTH) || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("cosim_endpoint_rx_fifo: DEPTH must be a power of two and >= %0d", MIN_DEPTH);
    end

    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_overflow;
    logic                      r_rstn_q;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_dn_valid;
    logic [CNT_W:0]            w_count_resv;
    logic [TYPE_SIZE_BITS-1:0] w_rdata;

    assign w_dn_valid = (r_count != {CNT_W{1'b0}});
    assign w_pop      = w_dn_valid && bus.dn_ready;
    assign w_push     = bus.up_valid && ((r_count < CNT_W'(DEPTH)) || w_pop);
    assign w_drop     = bus.up_valid && !w_push;

    // The in-flight message counts against space so one slot of slack covers
    // the endpoint's ready-to-valid latency.
    assign w_count_resv = {1'b0, r_count} + {{CNT_W{1'b0}}, bus.up_valid};

    assign bus.up_ready  = r_rstn_q && (w_count_resv <= (CNT_W + 1)'(DEPTH - 1));
    assign bus.dn_valid  = w_dn_valid;
    assign bus.dn_data   = w_rdata;
    assign bus.occupancy = r_count;
    assign bus.overflow  = r_overflow;

    // Holds up_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstn_q <= 1'b0;
        end else begin
            r_rstn_q <= 1'b1;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    cosim_rx_fifo_mem #(
        .DATA_W (TYPE_SIZE_BITS),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.up_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    cosim_rx_fifo_chk #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (clk),
        .rstn    (rstn),
        .i_count (r_count),
        .i_pop   (w_pop)
    );

endmodule

// File: tb/tb_cosim_endpoint_rx_fifo.sv
// Bench for cosim_endpoint_rx_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cosim_endpoint_rx_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    cosim_endpoint_rx_fifo_if #(.TYPE_SIZE_BITS(W), .DEPTH(DEPTH)) bus ();

    cosim_endpoint_rx_fifo #(.TYPE_SIZE_BITS(W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored payloads.
    logic [W-1:0] mq[$];
    bit m_rq   = 1'b0;
    bit m_ovf  = 1'b0;
    int n_push = 0;
    int n_drop = 0;

    always @(posedge clk or negedge rstn) begin
        bit do_pop;
        bit do_push;
        if (!rstn) begin
            mq.delete();
            m_rq  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && (bus.dn_ready === 1'b1);
            do_push = (bus.up_valid === 1'b1) && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back(bus.up_data);
                n_push++;
            end
            if ((bus.up_valid === 1'b1) && !do_push) begin
                m_ovf = 1'b1;
                n_drop++;
            end else if (bus.clr_overflow === 1'b1) begin
                m_ovf = 1'b0;
            end
            m_rq = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = m_rq && ((mq.size() + int'(bus.up_valid)) <= DEPTH - 1);
        check("mdl_up_ready", 64'(bus.up_ready), 64'(exp_rdy));
        check("mdl_dn_valid", 64'(bus.dn_valid), 64'(mq.size() != 0));
        check("mdl_occupancy", 64'(bus.occupancy), 64'(mq.size()));
        check("mdl_overflow", 64'(bus.overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            check("mdl_dn_data", 64'(bus.dn_data), 64'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Endpoint model: ready sampled at one edge licenses one valid cycle after it.
    bit ep_rdy = 1'b0;

    task automatic ep_cycle(input bit want, input logic [W-1:0] d, output bit sent);
        sent         = ep_rdy && want;
        bus.up_valid = sent;
        bus.up_data  = sent ? d : 32'h0;
        #1;
        ep_rdy = bus.up_ready;
        tick();
    endtask

    task automatic fill(input logic [W-1:0] base);
        int  n;
        bit  s;
        n = 0;
        for (int c = 0; c < 40 && n < DEPTH; c++) begin
            ep_cycle(1'b1, base + 32'(n), s);
            if (s) n++;
        end
        bus.up_valid = 1'b0;
        bus.up_data  = 32'h0;
        #1;
        check("fill_count", 64'(n), 64'(DEPTH));
    endtask

    logic [W-1:0] exp_seq [4];
    int           drops_before;
    bit           s;

    initial begin
        rstn             = 1'b0;
        bus.up_valid     = 1'b0;
        bus.up_data      = 32'h0;
        bus.dn_ready     = 1'b0;
        bus.clr_overflow = 1'b0;

        // Reset release: up_ready held low for one cycle.
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("rel_up_ready_first", 64'(bus.up_ready), 64'd0);
        tick();
        check("rel_up_ready_after", 64'(bus.up_ready), 64'd1);
        check("rel_dn_valid", 64'(bus.dn_valid), 64'd0);
        check("rel_occupancy", 64'(bus.occupancy), 64'd0);
        check("rel_overflow", 64'(bus.overflow), 64'd0);

        // Single pulse, no bypass, one-cycle write-to-read latency.
        bus.up_valid = 1'b1;
        bus.up_data  = 32'hDEADBEEF;
        bus.dn_ready = 1'b1;
        #1;
        check("pulse_no_bypass", 64'(bus.dn_valid), 64'd0);
        tick();
        bus.up_valid = 1'b0;
        bus.up_data  = 32'h0;
        #1;
        check("pulse_dn_valid", 64'(bus.dn_valid), 64'd1);
        check("pulse_dn_data", 64'(bus.dn_data), 64'hDEADBEEF);
        tick();
        check("pulse_dn_valid_gone", 64'(bus.dn_valid), 64'd0);
        check("pulse_occ_zero", 64'(bus.occupancy), 64'd0);

        // Endpoint fills the FIFO against dn_ready=0 without a drop.
        bus.dn_ready = 1'b0;
        ep_rdy       = 1'b0;
        fill(32'h1);
        check("fill_occ", 64'(bus.occupancy), 64'd4);
        check("fill_up_ready", 64'(bus.up_ready), 64'd0);
        check("fill_overflow", 64'(bus.overflow), 64'd0);
        bus.dn_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", 64'(bus.dn_valid), 64'd1);
            check("drain_data", 64'(bus.dn_data), 64'(k));
            tick();
        end
        bus.dn_ready = 1'b0;
        check("drain_empty", 64'(bus.occupancy), 64'd0);

        // Forced push into a full FIFO is dropped and flagged.
        fill(32'h11);
        bus.up_valid = 1'b1;
        bus.up_data  = 32'h55;
        tick();
        bus.up_valid = 1'b0;
        #1;
        check("drop_overflow", 64'(bus.overflow), 64'd1);
        check("drop_occ", 64'(bus.occupancy), 64'd4);
        check("drop_head", 64'(bus.dn_data), 64'h11);
        bus.up_valid     = 1'b1;
        bus.clr_overflow = 1'b1;
        tick();
        bus.up_valid     = 1'b0;
        #1;
        check("drop_set_wins", 64'(bus.overflow), 64'd1);
        tick();
        bus.clr_overflow = 1'b0;
        #1;
        check("clr_overflow", 64'(bus.overflow), 64'd0);

        // Full with simultaneous push and pop: push accepted.
        bus.up_valid = 1'b1;
        bus.up_data  = 32'hAA;
        bus.dn_ready = 1'b1;
        tick();
        bus.up_valid = 1'b0;
        bus.dn_ready = 1'b0;
        #1;
        check("fullpp_occ", 64'(bus.occupancy), 64'd4);
        check("fullpp_overflow", 64'(bus.overflow), 64'd0);
        check("fullpp_head", 64'(bus.dn_data), 64'h12);
        exp_seq = '{32'h12, 32'h13, 32'h14, 32'hAA};
        bus.dn_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fullpp_order", 64'(bus.dn_data), 64'(exp_seq[k]));
            tick();
        end
        check("fullpp_empty", 64'(bus.dn_valid), 64'd0);

        // Random traffic with a well-behaved endpoint, reset asserted mid-run.
        drops_before = n_drop;
        n_push       = 0;
        ep_rdy       = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                bus.dn_ready = 1'b0;
                repeat (3) ep_cycle(1'b1, $urandom(), s);
                bus.up_valid = 1'b0;
                #1;
                check("pre_reset_nonempty", 64'(bus.occupancy != 0), 64'd1);
                rstn = 1'b0;
                #1;
                check("async_rst_dn_valid", 64'(bus.dn_valid), 64'd0);
                check("async_rst_occ", 64'(bus.occupancy), 64'd0);
                check("async_rst_up_ready", 64'(bus.up_ready), 64'd0);
                tick();
                rstn   = 1'b1;
                ep_rdy = 1'b0;
            end
            bus.dn_ready = ($urandom_range(0, 3) != 0);
            ep_cycle($urandom_range(0, 2) != 0, $urandom(), s);
        end
        bus.up_valid = 1'b0;
        bus.dn_ready = 1'b1;
        repeat (8) tick();
        check("rand_no_drops", 64'(n_drop - drops_before), 64'd0);
        check("rand_wraps_gt_100", 64'(n_push > 100 * DEPTH), 64'd1);
        check("rand_final_empty", 64'(bus.occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
